// File: rtl/vga_sync_if.sv
// vga_sync_if: raster timing bundle from the sync generator to the pixel generators and connector
interface vga_sync_if;
  logic        p_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic [15:0] frame_cnt;
  modport master (output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start, frame_cnt);
  modport slave  (input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start, frame_cnt);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator with registered syncs and coordinates; define VGA_SYNC_FRAME_CNT_EN to build the frame counter
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  vga_sync_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] X_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  logic          adv;
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic          p_tick_q, p_tick_d, frame_start_q, frame_start_d;
  // next counter state, with every output decoded from that next state so it lands with the counters
  always_comb begin
    adv = div_q == DIV_MAX;
    div_d = adv ? '0 : div_q + 1'b1;
    x_d = !adv ? x_q : (x_q == X_MAX ? '0 : x_q + 10'd1);
    y_d = !(adv && x_q == X_MAX) ? y_q : (y_q == Y_MAX ? '0 : y_q + 10'd1);
    hsync_d = !(x_d >= HS_LO && x_d < HS_HI);
    vsync_d = !(y_d >= VS_LO && y_d < VS_HI);
    video_on_d = x_d < X_VIS && y_d < Y_VIS;
    p_tick_d = adv;
    frame_start_d = adv && x_d == '0 && y_d == '0;
  end
  // timing state; reset parks the raster on the last pixel so the first advance lands on (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      x_q           <= X_MAX;
      y_q           <= Y_MAX;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      p_tick_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      p_tick_q      <= p_tick_d;
      frame_start_q <= frame_start_d;
    end
  end
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  // count frames in step with frame_start so the new count shows alongside (0,0)
  always_comb frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  // frame counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else frame_cnt_q <= frame_cnt_d;
  end
  assign vga.frame_cnt = frame_cnt_q;
`else
  assign vga.frame_cnt = '0;
`endif
  assign vga.p_tick      = p_tick_q;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.video_on    = video_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks a default-timing and a shrunken-timing vga_sync_gen against a linear-position raster model
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n;
  int   total = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  vga_sync_if big_if();
  vga_sync_if sml_if();
  vga_sync_gen u_big (.clk(clk), .rst_n(rst_n), .vga(big_if));
  vga_sync_gen #(
    .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_sml (.clk(clk), .rst_n(rst_n), .vga(sml_if));
  // rising edges seen since the last reset release; the whole model is a function of this
  always @(posedge clk or negedge rst_n) n <= !rst_n ? 0 : n + 1;
  task automatic chk(input string nm, input int cd, hd, hf, hs, hb, vd, vf, vs, vb,
                     input logic pt, input logic [9:0] px, py, input logic von, hsy, vsy, fst,
                     input logic [15:0] fcn);
    longint ht, vt, fr, a, l, ex, ey, efc;
    logic ept, efs, evon, ehs, evs;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    fr = ht * vt;
    a = longint'(n) / cd;
    l = (fr - 1 + a) % fr;
    ex = l % ht;
    ey = l / ht;
    ept = n > 0 && (n % cd) == 0;
    efs = ept && l == 0;
    evon = ex < hd && ey < vd;
    ehs = !(ex >= hd + hf && ex < hd + hf + hs);
    evs = !(ey >= vd + vf && ey < vd + vf + vs);
`ifdef VGA_SYNC_FRAME_CNT_EN
    efc = ((fr - 1 + a) / fr) % 65536;
`else
    efc = 0;
`endif
    total++;
    if (pt !== ept || longint'(px) != ex || longint'(py) != ey || von !== evon || hsy !== ehs ||
        vsy !== evs || fst !== efs || longint'(fcn) != efc) begin
      fails++;
      $display("FAIL %s n=%0d got tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b fc=%0d want tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b fc=%0d",
               nm, n, pt, px, py, von, hsy, vsy, fst, fcn, ept, ex, ey, evon, ehs, evs, efs, efc);
    end
  endtask
  task automatic lit(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask
  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    chk("big", 4, 640, 16, 96, 48, 480, 10, 2, 33, big_if.p_tick, big_if.pixel_x, big_if.pixel_y,
        big_if.video_on, big_if.hsync, big_if.vsync, big_if.frame_start, big_if.frame_cnt);
    chk("sml", 3, 8, 2, 3, 2, 6, 1, 2, 1, sml_if.p_tick, sml_if.pixel_x, sml_if.pixel_y,
        sml_if.video_on, sml_if.hsync, sml_if.vsync, sml_if.frame_start, sml_if.frame_cnt);
  end
  task automatic pin_reset(input string nm);
    lit({nm, "_x"}, big_if.pixel_x, 799);
    lit({nm, "_y"}, big_if.pixel_y, 524);
    lit({nm, "_hs"}, big_if.hsync, 1);
    lit({nm, "_vs"}, big_if.vsync, 1);
    lit({nm, "_von"}, big_if.video_on, 0);
    lit({nm, "_tick"}, big_if.p_tick, 0);
    lit({nm, "_fs"}, big_if.frame_start, 0);
    lit({nm, "_fc"}, big_if.frame_cnt, 0);
    lit({nm, "_sml_x"}, sml_if.pixel_x, 14);
    lit({nm, "_sml_y"}, sml_if.pixel_y, 9);
  endtask
  task automatic release_and_pin(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit({nm, "_tick_early"}, big_if.p_tick, 0);
    @(posedge clk);
    @(negedge clk);
    lit({nm, "_tick4"}, big_if.p_tick, 1);
    lit({nm, "_fs4"}, big_if.frame_start, 1);
    lit({nm, "_x4"}, big_if.pixel_x, 0);
    lit({nm, "_y4"}, big_if.pixel_y, 0);
    lit({nm, "_von4"}, big_if.video_on, 1);
  endtask
  initial begin
    int hs_low, von_cnt, hs_first, hs_last, vs_low, fs_cnt;
    repeat (5) @(negedge clk);
    pin_reset("rst");
    release_and_pin("rel");
    hs_low = 0; von_cnt = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 3200; i++) begin
      if (big_if.p_tick) begin
        if (!big_if.hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(big_if.pixel_x);
          hs_last = int'(big_if.pixel_x);
        end
        if (big_if.video_on) von_cnt++;
      end
      @(negedge clk);
    end
    lit("line_hs_ticks", hs_low, 96);
    lit("line_hs_first", hs_first, 656);
    lit("line_hs_last", hs_last, 751);
    lit("line_von_ticks", von_cnt, 640);
    lit("line_next_y", big_if.pixel_y, 1);
    vs_low = 0; fs_cnt = 0;
    for (int i = 0; i < 450; i++) begin
      if (sml_if.p_tick && !sml_if.vsync) vs_low++;
      if (sml_if.frame_start) fs_cnt++;
      @(negedge clk);
    end
    lit("sml_vs_ticks", vs_low, 30);
    lit("sml_fs_count", fs_cnt, 1);
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(3000, 200)) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 pin_reset("async");
      repeat ($urandom_range(3, 1)) @(posedge clk);
      release_and_pin("rerel");
    end
    repeat (1400) @(negedge clk);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
